// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences each instruction through one state per clock
// and drives the datapath selects, enables, ALU control and memory write strobe.
module mc_controller #(
  parameter int RETW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  output logic            memtoreg,
  output logic            regdst,
  output logic            iord,
  output logic            pcsrc,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [2:0]      alucontrol,
  output logic            irwrite,
  output logic            memwrite,
  output logic            regwrite,
  output logic            pcen,
  output logic            jump,
  output logic            illegal,
  output logic [3:0]      state_o,
  output logic [RETW-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t          state_q, state_d;
  logic [RETW-1:0] retired_q, retired_d;

  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       illegal_s;
  logic       op_known;
  logic       retire_evt;

  // Unknown funct codes fall back to add rather than flagging an error.
  function automatic logic [2:0] alu_dec(input logic [1:0] aop, input logic [5:0] fn);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (aop)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (fn)
          6'b100000: ctl = ALU_ADD;
          6'b100010: ctl = ALU_SUB;
          6'b100100: ctl = ALU_AND;
          6'b100101: ctl = ALU_OR;
          6'b101010: ctl = ALU_SLT;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  always_comb begin
    op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Every terminal state returns to FETCH, so leaving one retires an instruction.
  always_comb begin
    retire_evt = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                 (state_q == S_BRANCH) || (state_q == S_ADDIWB) || (state_q == S_JUMP);
    retired_d  = retire_evt ? (retired_q + RETW'(1)) : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        illegal_s = ~op_known;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 1'b1;
        branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes and enables are held low for as long as reset is asserted.
  assign alucontrol = alu_dec(aluop, funct);
  assign irwrite    = irwrite_s & reset;
  assign memwrite   = memwrite_s & reset;
  assign regwrite   = regwrite_s & reset;
  assign illegal    = illegal_s & reset;
  assign pcen       = (pcwrite | (branch & zero)) & reset;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule
